// File: rtl/cmd_responder.sv
// rtl/cmd_responder.sv - target-side decoder/responder for the 3-bit active-low command bus
module cmd_responder #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    cmd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          wr_ack,
  output logic          err,
  output logic          open_o
);

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b101;
  localparam logic [2:0] CMD_RD  = 3'b110;
  localparam int         DEPTH   = 1 << AW;

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("cmd_responder: RD_LAT must be in 1..4");
    end
  endgenerate

  typedef enum logic {IDLE, OPEN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   open_addr;
  logic [DW-1:0]   mem [DEPTH];
  logic [RD_LAT-1:0] pipe_v;
  logic [DW-1:0]   pipe_d [RD_LAT];
  logic            load_addr, do_wr, do_rd, bad_cmd;

  always_comb begin
    state_d   = state_q;
    load_addr = 1'b0;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    bad_cmd   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd == CMD_ACT) begin
          load_addr = 1'b1;
          state_d   = OPEN;
        end else if (cmd != CMD_NOP) begin
          bad_cmd = 1'b1;
        end
      end
      OPEN: begin
        case (cmd)
          CMD_ACT: load_addr = 1'b1;
          CMD_WR:  do_wr     = 1'b1;
          CMD_RD:  do_rd     = 1'b1;
          CMD_NOP: state_d   = IDLE;
          default: begin
            bad_cmd = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      open_addr <= '0;
      wr_ack    <= 1'b0;
      err       <= 1'b0;
      pipe_v    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_d[i] <= '0;
    end else begin
      state_q <= state_d;
      wr_ack  <= do_wr;
      err     <= bad_cmd;
      if (load_addr) open_addr <= addr;
      if (do_wr) mem[open_addr] <= wdata;
      // Data is zeroed on non-read slots so rdata reads 0 whenever rvalid is low.
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      pipe_v[0] <= do_rd;
      pipe_d[0] <= do_rd ? mem[open_addr] : '0;
    end
  end

  assign rvalid = pipe_v[RD_LAT-1];
  assign rdata  = pipe_d[RD_LAT-1];
  assign open_o = (state_q == OPEN);

endmodule
